// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle RV32I control FSM with memory watchdog (optional SEQ_SINGLE_STEP_EN)
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter logic [31:0] INSTRET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        dec_reg_write,
    input  logic        dec_mem_write,
    input  logic        take_pc_target,
    input  logic        mem_ready,
    input  logic        halt_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        pc_write,
    output logic        pc_sel,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [31:0]     instret_q;
    logic            retire, legal, halt_exit, stop_after;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q, step_rise, step_active_q;

    assign step_rise = step & ~step_q;

    // A stepped instruction always lands back in HALT, whatever halt_req says.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q        <= 1'b0;
            step_active_q <= 1'b0;
        end else begin
            step_q <= step;
            if (state_q == S_HALT && step_rise)
                step_active_q <= 1'b1;
            else if (state_d == S_HALT || state_d == S_FAULT)
                step_active_q <= 1'b0;
        end
    end

    assign halt_exit  = !halt_req || step_rise;
    assign stop_after = halt_req || (opcode == OP_SYSTEM) || step_active_q;
`else
    assign halt_exit  = !halt_req;
    assign stop_after = halt_req || (opcode == OP_SYSTEM);
`endif

    always_comb begin
        legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_IDLE:   state_d = halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE)
                    state_d = S_MEM;
                else if (opcode == OP_BRANCH)
                    retire = 1'b1;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = dec_mem_write;
                if (mem_ready) begin
                    if (opcode == OP_STORE)
                        retire = 1'b1;
                    else
                        state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we  = dec_reg_write;
                retire = 1'b1;
            end
            S_HALT:   if (halt_exit) state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
        endcase
        if (retire) begin
            pc_write = 1'b1;
            pc_sel   = take_pc_target;
            state_d  = stop_after ? S_HALT : S_FETCH;
        end
        // The wd_q value here counts earlier stall cycles; this cycle makes MEM_TIMEOUT.
        if (MEM_TIMEOUT != 0 && mem_req && !mem_ready && wd_q == TO_LAST)
            state_d = S_FAULT;
    end

    always_comb begin
        wd_d = '0;
        if (mem_req && !mem_ready && state_d == state_q)
            wd_d = wd_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            instret_q <= INSTRET_RST;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = (state_q == S_FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

    localparam logic [31:0] PRESET = 32'hFFFF_FFFE;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;
    localparam logic [6:0] OP_ALU = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_SYSTEM = 7'b1110011;
    localparam int NEVER = 999;

    typedef struct packed {
        logic [2:0] st;
        logic req, sel, we, irw, rfw, pcw, pcs, rdy;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        dec_reg_write = 1'b0, dec_mem_write = 1'b0, take_pc_target = 1'b0;
    logic        mem_ready = 1'b0, halt_req = 1'b0;
    logic        pc_write, pc_sel, ir_write, mem_req, mem_addr_sel, mem_we, rf_we, halted, fault;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        w_pc_write, w_pc_sel, w_ir_write, w_mem_req, w_mem_addr_sel, w_mem_we, w_rf_we;
    logic        w_halted, w_fault;
    logic [2:0]  w_state;
    logic [31:0] w_instret;

    int          checks = 0, failures = 0, n_instr = 0;
    logic [31:0] m_instret = 32'd0;
    logic [6:0]  legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .dec_reg_write(dec_reg_write),
        .dec_mem_write(dec_mem_write), .take_pc_target(take_pc_target), .mem_ready(mem_ready),
        .halt_req(halt_req), .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
        .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .rf_we(rf_we),
        .state(state), .halted(halted), .fault(fault), .instret(instret)
    );

    multicycle_sequencer #(.MEM_TIMEOUT(255), .TO_W(8), .INSTRET_RST(PRESET)) dut_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .dec_reg_write(dec_reg_write),
        .dec_mem_write(dec_mem_write), .take_pc_target(take_pc_target), .mem_ready(mem_ready),
        .halt_req(halt_req), .pc_write(w_pc_write), .pc_sel(w_pc_sel), .ir_write(w_ir_write),
        .mem_req(w_mem_req), .mem_addr_sel(w_mem_addr_sel), .mem_we(w_mem_we), .rf_we(w_rf_we),
        .state(w_state), .halted(w_halted), .fault(w_fault), .instret(w_instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic req, sel, we, irw, rfw, pcw, pcs, rdy);
        exp_t e;
        e = {st, req, sel, we, irw, rfw, pcw, pcs, rdy};
        return e;
    endfunction

    // Observed vector: state, mem_req, mem_addr_sel, mem_we, ir_write, rf_we, pc_write, pc_sel, halted, fault
    task automatic chk_cycle(input string tag, input exp_t e);
        logic [11:0] obs, exp;
        obs = {state, mem_req, mem_addr_sel, mem_we, ir_write, rf_we, pc_write, pc_sel, halted, fault};
        exp = {e.st, e.req, e.sel, e.we, e.irw, e.rfw, e.pcw, e.pcs, e.st == S_HALT, e.st == S_FAULT};
        chk(tag, {20'd0, obs}, {20'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        halt_req = 1'b0;
        #1;
        chk("reset.outputs", {state, mem_req, mem_addr_sel, mem_we, ir_write, rf_we, pc_write, pc_sel,
                              halted, fault}, 32'd0);
        chk("reset.instret", instret, 32'd0);
        chk("reset.instret_preset", w_instret, PRESET);
        m_instret = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_cycle("reset.idle", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
    endtask

    // Builds the expected cycle trace of one instruction from the sequencing rules, then plays it.
    task automatic run_instr(input logic [6:0] op, input int fst, input int mst, input logic dmw,
                             input logic drw, input logic take, input int hat, output logic to_halt);
        exp_t q[$];
        logic ld, st, br;
        ld = (op == OP_LOAD);
        st = (op == OP_STORE);
        br = (op == OP_BRANCH);
        for (int i = 0; i < fst; i++) q.push_back(mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 1));
        q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(S_EXEC, 0, 0, 0, 0, 0, br, br & take, 0));
        if (ld || st) begin
            for (int i = 0; i < mst; i++) q.push_back(mk(S_MEM, 1, 1, dmw, 0, 0, 0, 0, 0));
            q.push_back(mk(S_MEM, 1, 1, dmw, 0, 0, st, st & take, 1));
        end
        if (!br && !st) q.push_back(mk(S_WB, 0, 0, 0, 0, drw, 1, take, 0));
        opcode = op;
        dec_mem_write = dmw;
        dec_reg_write = drw;
        take_pc_target = take;
        foreach (q[i]) begin
            halt_req = (i >= hat);
            mem_ready = (q[i].st == S_FETCH || q[i].st == S_MEM) ? q[i].rdy : 1'($urandom);
            #1;
            chk_cycle($sformatf("i%0d.op%b.c%0d", n_instr, op, i), q[i]);
            @(negedge clk);
        end
        m_instret = m_instret + 32'd1;
        to_halt = ((q.size() - 1) >= hat) || (op == OP_SYSTEM);
        chk($sformatf("i%0d.instret", n_instr), instret, m_instret);
        chk($sformatf("i%0d.instret_wrap", n_instr), w_instret, PRESET + m_instret);
        n_instr++;
    endtask

    task automatic halt_seq(input int n);
        for (int i = 0; i <= n; i++) begin
            halt_req = (i < n);
            mem_ready = 1'($urandom);
            #1;
            chk_cycle($sformatf("halt%0d.c%0d", n_instr, i), mk(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
    endtask

    initial begin
        logic h;
        @(negedge clk);
        do_reset();

        run_instr(OP_ALU, 0, 0, 0, 1, 0, NEVER, h);
        chk("alu.no_halt", 32'(h), 32'd0);
        run_instr(OP_LOAD, 3, 2, 0, 1, 0, NEVER, h);
        run_instr(OP_STORE, 0, 0, 1, 1, 1, NEVER, h);
        run_instr(OP_BRANCH, 0, 0, 0, 1, 1, NEVER, h);
        run_instr(OP_LOAD, 1, 1, 0, 1, 0, 3, h);
        halt_seq(2);
        run_instr(OP_SYSTEM, 0, 0, 0, 0, 0, NEVER, h);
        halt_seq(0);

        for (int k = 0; k < 40; k++) begin
            int hat;
            hat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : NEVER;
            run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), 1'($urandom), hat, h);
            if (h) halt_seq($urandom_range(0, 2));
        end

        // Illegal opcode: fetch and decode, then locked in FAULT.
        opcode = 7'b1111111;
        halt_req = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk_cycle("illegal.fetch", mk(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 1));
        @(negedge clk);
        #1;
        chk_cycle("illegal.decode", mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            halt_req = 1'($urandom);
            #1;
            chk_cycle($sformatf("illegal.fault%0d", i), mk(S_FAULT, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        do_reset();

        // Watchdog: four unacknowledged fetch cycles, then FAULT.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cycle($sformatf("timeout.stall%0d", i), mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
        #1;
        chk_cycle("timeout.fault", mk(S_FAULT, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        do_reset();

        run_instr(OP_ALU, 1, 0, 0, 1, 1, NEVER, h);

        // Asynchronous reset in the middle of a stalled data access.
        opcode = OP_LOAD;
        mem_ready = 1'b1;
        #1;
        chk_cycle("abort.fetch", mk(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 1));
        @(negedge clk);
        #1;
        chk_cycle("abort.decode", mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk_cycle("abort.exec", mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        mem_ready = 1'b0;
        dec_mem_write = 1'b1;
        #1;
        chk_cycle("abort.mem", mk(S_MEM, 1, 1, 1, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        chk("abort.outputs", {state, mem_req, mem_addr_sel, mem_we, ir_write, rf_we, pc_write, pc_sel,
                              halted, fault}, 32'd0);
        chk("abort.instret", instret, 32'd0);
        @(negedge clk);
        do_reset();
        run_instr(OP_ALU, 0, 0, 0, 1, 0, NEVER, h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
